// File: rtl/nn_compute_initiator.sv
// nn_compute_initiator: launches one inference on the layer sequencer, then scans the ten output scores for the argmax.
// Optional macro NN_INIT_PERF_EN adds the Cycle_count output (RUN-phase length of the last inference).
module nn_compute_initiator #(
   parameter int TIMEOUT_CYCLES = 2047,
   parameter int SCORE_W        = 16
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      Req_valid,
   output logic                      Req_ready,
   output logic                      Compute,
   input  logic                      R,
   input  logic [2:0]                Layer,
   output logic [3:0]                Score_sel,
   input  logic signed [SCORE_W-1:0] Score,
   output logic                      Result_valid,
   input  logic                      Result_ready,
   output logic [3:0]                Digit,
   output logic signed [SCORE_W-1:0] Max_score,
   output logic                      Timeout
`ifdef NN_INIT_PERF_EN
   ,
   output logic [15:0]               Cycle_count
`endif
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RUN    = 3'd1;
   localparam logic [2:0] DRAIN  = 3'd2;
   localparam logic [2:0] SCAN   = 3'd3;
   localparam logic [2:0] RESULT = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic [CNT_W-1:0] run_cnt;
   logic             seen_l3;
   logic [3:0]       scan_idx;
   logic             run_done;
   logic             run_expired;
   logic             accept;

   assign accept      = (state == IDLE) && Req_valid && R;
   assign run_done    = seen_l3 && (Layer == 3'b000);
   assign run_expired = (run_cnt == CNT_LAST);

   assign Req_ready    = (state == IDLE) && R;
   assign Compute      = (state == RUN);
   assign Result_valid = (state == RESULT);
   assign Score_sel    = ((state == SCAN) && (scan_idx <= 4'd9)) ? scan_idx : 4'd0;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (run_done || run_expired) state_next = DRAIN;
         DRAIN:   if (R) state_next = Timeout ? RESULT : SCAN;
         SCAN:    if (scan_idx == 4'd10) state_next = RESULT;
         RESULT:  if (Result_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Score arrives one cycle after its address, so scan step k judges class k-1; step 1 seeds the maximum.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         run_cnt   <= '0;
         seen_l3   <= 1'b0;
         scan_idx  <= 4'd0;
         Digit     <= 4'd0;
         Max_score <= '0;
         Timeout   <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  run_cnt <= '0;
                  seen_l3 <= 1'b0;
                  Timeout <= 1'b0;
               end
            end
            RUN: begin
               run_cnt <= run_cnt + CNT_W'(1);
               if (Layer == 3'b100) seen_l3 <= 1'b1;
               if (run_done) begin
                  Timeout <= 1'b0;
               end else if (run_expired) begin
                  Timeout   <= 1'b1;
                  Digit     <= 4'hF;
                  Max_score <= '0;
               end
            end
            DRAIN: scan_idx <= 4'd0;
            SCAN: begin
               scan_idx <= scan_idx + 4'd1;
               if (scan_idx == 4'd1) begin
                  Digit     <= 4'd0;
                  Max_score <= Score;
               end else if ((scan_idx != 4'd0) && (Score > Max_score)) begin
                  Digit     <= scan_idx - 4'd1;
                  Max_score <= Score;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef NN_INIT_PERF_EN
   logic [15:0] perf_cnt;

   // perf_cnt counts RUN cycles already completed, so the latched length includes the exit cycle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         perf_cnt    <= 16'd0;
         Cycle_count <= 16'd0;
      end else if (accept) begin
         perf_cnt <= 16'd0;
      end else if (state == RUN) begin
         if (perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 16'd1;
         if (state_next == DRAIN) begin
            Cycle_count <= (perf_cnt == 16'hFFFF) ? 16'hFFFF : perf_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_nn_compute_initiator.sv
// Self-checking bench for nn_compute_initiator: randomized inferences against a transaction-level model.
// Builds with or without NN_INIT_PERF_EN.
module tb_nn_compute_initiator;

   localparam int SW = 16;
   localparam int TO = 2047;

   logic                 Clk = 1'b0;
   logic                 Reset_n;
   logic                 Req_valid;
   logic                 R;
   logic                 Result_ready;
   logic [2:0]           Layer = 3'b000;
   logic signed [SW-1:0] Score = '0;
   logic                 Req_ready;
   logic                 Compute;
   logic                 Result_valid;
   logic                 Timeout;
   logic [3:0]           Score_sel;
   logic [3:0]           Digit;
   logic signed [SW-1:0] Max_score;
`ifdef NN_INIT_PERF_EN
   logic [15:0]          Cycle_count;
`endif

   int checks   = 0;
   int failures = 0;

   // Model state: mphase 0 idle, 1 run, 2 drain, 3 scan, 4 result.
   int         mphase    = 0;
   int         run_cyc   = 0;
   int         scan_k    = 0;
   int         exp_len   = 0;
   bit         exp_to    = 1'b0;
   int         exp_digit = 0;
   int         exp_max   = 0;
   logic [2:0] pattern [4096];
   int         pat_len   = 0;
   int         scores [10];
   int         last_sel  = 0;
   bit         fresh     = 1'b1;
   int         comp_cnt  = 0;
   int         got_digit = 0;
   int         got_max   = 0;
   int         got_to    = 0;
   int         got_len   = 0;

   nn_compute_initiator #(.TIMEOUT_CYCLES(TO), .SCORE_W(SW)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Req_valid    (Req_valid),
      .Req_ready    (Req_ready),
      .Compute      (Compute),
      .R            (R),
      .Layer        (Layer),
      .Score_sel    (Score_sel),
      .Score        (Score),
      .Result_valid (Result_valid),
      .Result_ready (Result_ready),
      .Digit        (Digit),
      .Max_score    (Max_score),
`ifdef NN_INIT_PERF_EN
      .Cycle_count  (Cycle_count),
`endif
      .Timeout      (Timeout)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // RUN length is the first cycle showing 000 after some earlier 100, capped by the timeout.
   function automatic void computeExpected();
      bit seen = 1'b0;
      exp_len = TO;
      exp_to  = 1'b1;
      for (int j = 1; j <= TO; j++) begin
         logic [2:0] ly;
         ly = (j <= pat_len) ? pattern[j-1] : 3'b000;
         if (seen && ly == 3'b000) begin
            exp_len = j;
            exp_to  = 1'b0;
            break;
         end
         if (ly == 3'b100) seen = 1'b1;
      end
      if (exp_to) begin
         exp_digit = 15;
         exp_max   = 0;
      end else begin
         exp_digit = 0;
         exp_max   = scores[0];
         for (int i = 1; i < 10; i++) begin
            if (scores[i] > exp_max) begin
               exp_digit = i;
               exp_max   = scores[i];
            end
         end
      end
   endfunction

   // Compare process: checks this cycle's outputs, then drives Layer/Score and advances the model.
   always @(negedge Clk) begin
      if (!Reset_n) begin
         checkOutput("rst_req_ready", Req_ready, R);
         checkOutput("rst_compute", Compute, 0);
         checkOutput("rst_result_valid", Result_valid, 0);
         checkOutput("rst_score_sel", Score_sel, 0);
         checkOutput("rst_digit", Digit, 0);
         checkOutput("rst_max_score", Max_score, 0);
         checkOutput("rst_timeout", Timeout, 0);
`ifdef NN_INIT_PERF_EN
         checkOutput("rst_cycle_count", Cycle_count, 0);
`endif
         mphase   = 0;
         scan_k   = 0;
         run_cyc  = 0;
         fresh    = 1'b1;
         comp_cnt = 0;
         Layer    = 3'b000;
      end else begin
         checkOutput("req_ready", Req_ready, (mphase == 0) && R);
         checkOutput("compute", Compute, mphase == 1);
         checkOutput("result_valid", Result_valid, mphase == 4);
         checkOutput("score_sel", Score_sel, (mphase == 3 && scan_k <= 9) ? scan_k : 0);
         if (mphase == 0 && fresh) begin
            checkOutput("idle_digit", Digit, 0);
            checkOutput("idle_max_score", Max_score, 0);
            checkOutput("idle_timeout", Timeout, 0);
         end
         if (mphase == 4) begin
            checkOutput("digit", Digit, exp_digit);
            checkOutput("max_score", Max_score, exp_max);
            checkOutput("timeout", Timeout, exp_to);
`ifdef NN_INIT_PERF_EN
            checkOutput("cycle_count", Cycle_count, exp_len);
`endif
            got_digit = Digit;
            got_max   = Max_score;
            got_to    = Timeout;
            got_len   = comp_cnt;
         end
         if (Compute) comp_cnt++;
         Layer = 3'b000;
         case (mphase)
            0: if (Req_valid && R) begin
                  mphase   = 1;
                  run_cyc  = 0;
                  fresh    = 1'b0;
                  comp_cnt = 0;
               end
            1: begin
                  run_cyc++;
                  if (run_cyc <= pat_len) Layer = pattern[run_cyc-1];
                  if (run_cyc == exp_len) mphase = 2;
               end
            2: if (R) begin
                  if (exp_to) mphase = 4;
                  else begin
                     mphase = 3;
                     scan_k = 0;
                  end
               end
            3: if (scan_k == 10) mphase = 4; else scan_k++;
            4: if (Result_ready) mphase = 0;
            default: mphase = 0;
         endcase
      end
      Score    = (last_sel <= 9) ? SW'(scores[last_sel]) : '0;
      last_sel = Score_sel;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic setPattern(input int n0, input int n1, input int n2, input int n3);
      int p = 0;
      for (int i = 0; i < n0; i++) begin pattern[p] = 3'b000; p++; end
      for (int i = 0; i < n1; i++) begin pattern[p] = 3'b001; p++; end
      for (int i = 0; i < n2; i++) begin pattern[p] = 3'b010; p++; end
      for (int i = 0; i < n3; i++) begin pattern[p] = 3'b100; p++; end
      pat_len = p;
   endtask

   // One inference: request, wait for the result (or reset at scan step 5), hold, then release.
   task automatic applyStimulus(input int hold, input bit poke, input bit rst_scan5);
      int guard;
      computeExpected();
      got_digit = -1;
      got_max   = -1;
      got_to    = -1;
      got_len   = -1;
      R         = 1'b1;
      Req_valid = 1'b1;
      tick();
      Req_valid = 1'b0;
      guard = 0;
      while (Result_valid !== 1'b1 && guard < 4000) begin
         R = ($urandom_range(0, 3) != 0);
         if (rst_scan5 && mphase == 3 && scan_k == 5) begin
            R       = 1'b1;
            Reset_n = 1'b0;
            tick();
            tick();
            Reset_n = 1'b1;
            tick();
            return;
         end
         tick();
         guard++;
      end
      if (Result_valid !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL result_wait: Result_valid %0b after %0d cycles, expected 1", Result_valid, guard);
         return;
      end
      R = 1'b1;
      if (poke) Req_valid = 1'b1;
      repeat (hold) tick();
      Req_valid    = 1'b0;
      Result_ready = 1'b1;
      tick();
      Result_ready = 1'b0;
      tick();
   endtask

   initial begin
      Reset_n      = 1'b0;
      Req_valid    = 1'b0;
      R            = 1'b0;
      Result_ready = 1'b0;
      for (int i = 0; i < 10; i++) scores[i] = 0;
      for (int i = 0; i < 4; i++) begin
         R = 1'($urandom_range(0, 1));
         tick();
      end
      Reset_n = 1'b1;
      R       = 1'b1;
      repeat (3) tick();

      $display("[TB] request held while R is low");
      R         = 1'b0;
      Req_valid = 1'b1;
      repeat (5) tick();

      $display("[TB] reference sequencer run");
      setPattern(0, 792, 27, 27);
      scores = '{5, -3, 9, 9, 0, 1, 2, -8, 4, 7};
      applyStimulus(20, 1'b1, 1'b0);
      checkOutput("ref_digit", got_digit, 2);
      checkOutput("ref_max_score", got_max, 9);
      checkOutput("ref_timeout", got_to, 0);
      checkOutput("ref_run_len", got_len, 847);

      $display("[TB] all scores equal and negative");
      setPattern(2, 5, 3, 4);
      for (int i = 0; i < 10; i++) scores[i] = -100;
      applyStimulus(3, 1'b0, 1'b0);
      checkOutput("tie_digit", got_digit, 0);
      checkOutput("tie_max_score", got_max, -100);

      $display("[TB] layer stuck at 001");
      setPattern(0, 3000, 0, 0);
      applyStimulus(2, 1'b0, 1'b0);
      checkOutput("stuck_timeout", got_to, 1);
      checkOutput("stuck_digit", got_digit, 15);
      checkOutput("stuck_max_score", got_max, 0);
      checkOutput("stuck_run_len", got_len, 2047);

      $display("[TB] completion on the last allowed cycle");
      setPattern(0, 2000, 20, 26);
      for (int i = 0; i < 10; i++) scores[i] = int'($urandom_range(0, 200)) - 100;
      applyStimulus(1, 1'b0, 1'b0);
      checkOutput("edge_done_timeout", got_to, 0);
      checkOutput("edge_done_run_len", got_len, 2047);

      $display("[TB] completion one cycle too late");
      setPattern(0, 2000, 20, 27);
      applyStimulus(1, 1'b0, 1'b0);
      checkOutput("edge_late_timeout", got_to, 1);
      checkOutput("edge_late_run_len", got_len, 2047);

      $display("[TB] reset during scan");
      setPattern(1, 3, 3, 3);
      for (int i = 0; i < 10; i++) scores[i] = 50 + i;
      applyStimulus(0, 1'b0, 1'b1);
      setPattern(1, 2, 2, 2);
      scores = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      applyStimulus(2, 1'b0, 1'b0);
      checkOutput("post_rst_digit", got_digit, 9);
      checkOutput("post_rst_max_score", got_max, 10);
      checkOutput("post_rst_run_len", got_len, 8);

      $display("[TB] randomized inferences");
      for (int t = 0; t < 8; t++) begin
         setPattern($urandom_range(0, 3), $urandom_range(1, 30), $urandom_range(1, 10), $urandom_range(1, 10));
         for (int i = 0; i < 10; i++) begin
            if (t % 2 == 0) scores[i] = int'($urandom_range(0, 10)) - 5;
            else            scores[i] = int'($urandom_range(0, 65535)) - 32768;
         end
         applyStimulus($urandom_range(0, 5), 1'(t % 2), 1'b0);
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      failures++;
      $display("[TB] FAIL watchdog: time %0t reached, expected completion earlier", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/nn_compute_initiator.md
NN_COMPUTE_INITIATOR -- requirements
Module: nn_compute_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2047: maximum cycles in RUN before abort.
REQ-002 SHALL have parameter SCORE_W, default 16: signed width of each class score.
REQ-003 SHALL have port Clk, input, 1: single clock; all logic on posedge; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port Reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port Req_valid, input, 1: host requests one inference.
REQ-006 SHALL have port Req_ready, output, 1: request can be accepted.
REQ-007 SHALL have port Compute, output, 1: start level to the layer sequencer.
REQ-008 SHALL have port R, input, 1: sequencer ready level.
REQ-009 SHALL have port Layer, input, 3: one-hot sequencer layer (001, 010, 100; 000 when no layer is loading).
REQ-010 SHALL have port Score_sel, output, 4: output-layer score read address, 0..9.
REQ-011 SHALL have port Score, input, SCORE_W: signed score at Score_sel, valid one cycle after the address.
REQ-012 SHALL have port Result_valid, output, 1: result available.
REQ-013 SHALL have port Result_ready, input, 1: host accepts result.
REQ-014 SHALL have port Digit, output, 4: argmax class index; 4'hF on timeout.
REQ-015 SHALL have port Max_score, output, SCORE_W: score of Digit; 0 on timeout.
REQ-016 SHALL have port Timeout, output, 1: result was aborted.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, SCAN, RESULT.
REQ-018 IDLE: Req_ready = R; on Req_valid && Req_ready, SHALL go to RUN and clear seen_l3 and the cycle counter.
REQ-019 RUN: Compute SHALL be 1; counter SHALL increment every cycle; seen_l3 SHALL set when Layer == 3'b100.
REQ-020 RUN exit: seen_l3 && Layer == 3'b000 -> DRAIN (Timeout = 0); counter == TIMEOUT_CYCLES-1 -> DRAIN (Timeout = 1); completion SHALL win if both occur in the same cycle.
REQ-021 DRAIN: Compute SHALL be 0 for at least one cycle; SHALL stay in DRAIN until R == 1, then go to SCAN, or to RESULT if Timeout = 1.
REQ-022 SCAN: Score_sel SHALL step 0..9, one per cycle; each Score SHALL be compared one cycle later; SCAN SHALL last 11 cycles, then go to RESULT.
REQ-023 Comparison SHALL be signed and strictly greater-than, so ties resolve to the lowest index; index 0 SHALL seed the running maximum unconditionally.
REQ-024 Timeout path SHALL set Digit = 4'hF and Max_score = 0.
REQ-025 RESULT: Result_valid = 1; Digit, Max_score and Timeout SHALL hold stable until Result_ready, then return to IDLE the next cycle.
REQ-026 Req_ready SHALL be 0 in every state except IDLE; Req_valid outside IDLE SHALL be ignored, not queued.
REQ-027 Score_sel SHALL be 0 outside SCAN; Compute SHALL be 0 outside RUN.

Reset
REQ-028 Reset_n low SHALL force IDLE asynchronously at any time, including mid-RUN or mid-SCAN.
REQ-029 Reset values: Compute 0, Result_valid 0, Digit 0, Max_score 0, Timeout 0, Score_sel 0, counter 0, seen_l3 0.
REQ-030 Req_ready after reset SHALL follow R.

Configuration
REQ-031 Macro NN_INIT_PERF_EN SHALL, when defined, add output Cycle_count [15:0]: RUN-phase length of the last inference, latched on RUN exit, saturating at 16'hFFFF, reset 0.
REQ-032 Without NN_INIT_PERF_EN, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Sequencer model (Layer 001 x792, 010 x27, 100 x27, then 000) with scores {5,-3,9,9,0,1,2,-8,4,7} -> Digit 2, Max_score 9, Timeout 0.
REQ-034 All scores = -100 -> Digit 0, Max_score -100 (tie and negative handling).
REQ-035 Layer stuck at 3'b001 -> Timeout 1, Digit F, Max_score 0 after exactly 2047 RUN cycles; Compute low in DRAIN.
REQ-036 Result_ready held low 20 cycles -> Result_valid and outputs stable; Req_valid meanwhile -> Req_ready 0, no new RUN.
REQ-037 Reset_n pulsed low during SCAN index 5 -> immediate IDLE, all outputs at reset values; next request runs normally.
REQ-038 R = 0 in IDLE with Req_valid = 1 -> Req_ready 0, Compute stays 0 until R rises.
